counter: RTL and testbench
==========================

// Module: counter
//
// PURPOSE
//   Free-running binary up-counter with count enable, WIDTH bits (default 8).
//   Generic counting primitive: cycle/event counting, address/sequence generation.
//   Holds when disabled; wraps modulo 2**WIDTH.
//   Single clock domain; no handshake.
//
// PARAMETERS
//   WIDTH      8    counter width in bits; legal range 1..32
//
// PORTS
//   clk        in   1      clock; all state updates on rising edge
//   reset      in   1      asynchronous, active-high reset; clears count
//   enable     in   1      count enable; sampled on rising edge of clk
//   value      out  WIDTH  current count; direct register output (no comb path)
//   Port order is fixed as listed: (clk, reset, enable, value).
//
// BEHAVIOUR
//   - One clock (clk). Reset is asynchronous and active-high:
//     reset=1 forces value=0 immediately, independent of clk.
//   - While reset=1: value held at 0; enable ignored.
//   - Reset value: value = {WIDTH{1'b0}}.
//   - Until the first reset assertion, value is undefined.
//     System integration must apply reset before use.
//   - On rising clk edge with reset=0:
//       enable=1 -> value <= value + 1, truncated to WIDTH bits.
//       enable=0 -> value holds.
//   - Latency: enable sampled at edge N is visible on value after edge N.
//     value changes only at clk edges or on reset assertion.
//   - Wrap-around: value = 2**WIDTH-1 (255 at default) with enable=1
//     -> next value = 0. No saturation, no overflow flag.
//   - Reset deassertion: first increment occurs at the first rising edge
//     after reset falls, if enable=1 at that edge.
//     The caller synchronises reset deassertion to clk.
//   - Reset asserted mid-count: value drops to 0 asynchronously.
//     It stays 0 while reset=1; no partial or delayed increment.
//   - Reset and enable both high at an edge: reset wins, value=0.
//   - enable toggling: each edge with enable=1 adds exactly 1.
//     Gaps simply hold; there is no internal history.
//   - Output is registered: value is glitch-free and has no combinational
//     dependence on enable.
//
// STRUCTURE
//   - Shared package: COUNTER_DEFAULT_WIDTH = 8.
//   - Shared package: typedef count_t = logic [COUNTER_DEFAULT_WIDTH-1:0].
//   - Single always block (async reset) holding the WIDTH-bit register
//     and the incrementer.
//   - No sub-module is required; the incrementer is inline.
//
// TESTING  (WIDTH=8, clk period 40 time units, check 3 units after each rising edge)
//   1. Hold reset=1 for 2 cycles, enable=1 -> value=0 every cycle.
//   2. Release reset, enable=0 for 3 cycles -> value stays 0.
//   3. enable=1 from reset release -> value reads 1,2,3,... on successive
//      edges; reaches 255 after 255 enabled edges.
//   4. From value=255, one more enabled edge -> value=0, then 1 (wrap).
//   5. Count to 10, drop enable for 4 cycles -> value holds 10; re-enable -> 11.
//   6. Count to 100, assert reset between clk edges -> value=0 before the
//      next edge and held there; deassert -> counting resumes 1,2,...

Source files
------------

// File: rtl/counter_pkg.sv
// Shared definitions for the counter primitive.
// Default width and a matching count type for users that keep the default.
// Ports: none (package only).
package counter_pkg;

  localparam int COUNTER_DEFAULT_WIDTH = 8;

  typedef logic [COUNTER_DEFAULT_WIDTH-1:0] count_t;

endpackage : counter_pkg

// File: rtl/counter.sv
// Purpose: WIDTH-bit free-running binary up-counter with count enable; wraps modulo 2**WIDTH.
// Latency: enable sampled at a rising clk edge shows on value right after that edge.
// Backpressure: none; enable gates counting, the counter never stalls or pushes back.
//
// Ports:
//   clk    - clock, all state updates on the rising edge
//   reset  - asynchronous active-high clear, forces value to 0 immediately
//   enable - count enable, sampled on the rising edge of clk
//   value  - current count, driven straight from the register
module counter
  import counter_pkg::*;
#(
  parameter int WIDTH = COUNTER_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  output logic [WIDTH-1:0] value
);

  logic [WIDTH-1:0] value_q;
  logic [WIDTH-1:0] value_d;

  // Truncating add gives the wrap from all-ones back to zero for free.
  assign value_d = enable ? value_q + WIDTH'(1) : value_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

  // Registered output only: no combinational path from enable to value.
  assign value = value_q;

endmodule : counter

// File: tb/tb_counter.sv
module tb_counter;
  import counter_pkg::*;

  logic   clk;
  logic   reset;
  logic   enable;
  count_t value;

  int     vectors;
  int     errors;
  int     model;
  count_t exp_q[$];
  count_t got;
  count_t expv;

  counter #(.WIDTH(COUNTER_DEFAULT_WIDTH)) dut (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .value  (value)
  );

  initial clk = 1'b0;
  always #20 clk = ~clk;

  // Drive one cycle of stimulus, record the expected result, then land
  // 3 time units after the rising edge where the result is sampled.
  task automatic drive_cycle(input logic en);
    enable = en;
    if (reset) model = 0;
    else if (en) model = (model + 1) % 256;
    exp_q.push_back(count_t'(model));
    @(posedge clk);
    #3;
  endtask

  task automatic test_reset();
    // Asynchronous clear before any clock edge has occurred.
    #5 reset = 1'b1;
    enable = 1'b1;
    model = 0;
    exp_q.push_back(count_t'(model));
    #1;
    got = value; expv = exp_q.pop_front(); vectors++;
    if (got !== expv) begin
      errors++;
      $display("FAIL reset_async: value=%0d expected=%0d", got, expv);
    end
    // Reset held with enable high: enable is ignored.
    for (int i = 0; i < 2; i++) begin
      drive_cycle(1'b1);
      got = value; expv = exp_q.pop_front(); vectors++;
      if (got !== expv) begin
        errors++;
        $display("FAIL reset_hold cyc%0d: value=%0d expected=%0d", i, got, expv);
      end
    end
  endtask

  task automatic test_idle_after_reset();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_cycle(1'b0);
      got = value; expv = exp_q.pop_front(); vectors++;
      if (got !== expv) begin
        errors++;
        $display("FAIL idle_hold cyc%0d: value=%0d expected=%0d", i, got, expv);
      end
    end
  endtask

  task automatic test_count_up();
    for (int i = 0; i < 255; i++) begin
      drive_cycle(1'b1);
      got = value; expv = exp_q.pop_front(); vectors++;
      if (got !== expv) begin
        errors++;
        $display("FAIL count_up step%0d: value=%0d expected=%0d", i, got, expv);
      end
    end
    // Independent check of the endpoint against a fixed constant.
    vectors++;
    if (value !== 8'd255) begin
      errors++;
      $display("FAIL count_top: value=%0d expected=255", value);
    end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 2; i++) begin
      drive_cycle(1'b1);
      got = value; expv = exp_q.pop_front(); vectors++;
      if (got !== expv) begin
        errors++;
        $display("FAIL wrap step%0d: value=%0d expected=%0d", i, got, expv);
      end
    end
  endtask

  task automatic test_enable_gap();
    while (model != 10) begin
      drive_cycle(1'b1);
      got = value; expv = exp_q.pop_front(); vectors++;
      if (got !== expv) begin
        errors++;
        $display("FAIL gap_ramp: value=%0d expected=%0d", got, expv);
      end
    end
    for (int i = 0; i < 4; i++) begin
      drive_cycle(1'b0);
      got = value; expv = exp_q.pop_front(); vectors++;
      if (got !== expv) begin
        errors++;
        $display("FAIL gap_hold cyc%0d: value=%0d expected=%0d", i, got, expv);
      end
    end
    drive_cycle(1'b1);
    got = value; expv = exp_q.pop_front(); vectors++;
    if (got !== expv) begin
      errors++;
      $display("FAIL gap_resume: value=%0d expected=%0d", got, expv);
    end
  endtask

  task automatic test_midcount_reset();
    while (model != 100) begin
      drive_cycle(1'b1);
      got = value; expv = exp_q.pop_front(); vectors++;
      if (got !== expv) begin
        errors++;
        $display("FAIL mid_ramp: value=%0d expected=%0d", got, expv);
      end
    end
    // Assert reset between edges; value must clear before the next edge.
    #10 reset = 1'b1;
    model = 0;
    exp_q.push_back(count_t'(model));
    #1;
    got = value; expv = exp_q.pop_front(); vectors++;
    if (got !== expv) begin
      errors++;
      $display("FAIL mid_async_clear: value=%0d expected=%0d", got, expv);
    end
    // Finish out the cycle so the following edge is back on the sampling grid.
    @(posedge clk);
    #3;
    got = value; vectors++;
    if (got !== 8'd0) begin
      errors++;
      $display("FAIL mid_reset_edge: value=%0d expected=0", got);
    end
    for (int i = 0; i < 2; i++) begin
      drive_cycle(1'b1);
      got = value; expv = exp_q.pop_front(); vectors++;
      if (got !== expv) begin
        errors++;
        $display("FAIL mid_reset_hold cyc%0d: value=%0d expected=%0d", i, got, expv);
      end
    end
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_cycle(1'b1);
      got = value; expv = exp_q.pop_front(); vectors++;
      if (got !== expv) begin
        errors++;
        $display("FAIL mid_resume step%0d: value=%0d expected=%0d", i, got, expv);
      end
    end
  endtask

  initial begin
    vectors = 0;
    errors  = 0;
    model   = 0;
    reset   = 1'b0;
    enable  = 1'b0;
    test_reset();
    test_idle_after_reset();
    test_count_up();
    test_wrap();
    test_enable_gap();
    test_midcount_reset();
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: left=%0d expected=0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time=%0t limit=200000", $time);
    $fatal(1);
  end

endmodule : tb_counter
